// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: drives an external one-bit full subtractor cell
// LSB-first and assembles Diff = A - B - Bin over WIDTH clocks.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             fs_A,
  output logic             fs_B,
  output logic             fs_Bin,
  input  logic             fs_Diff,
  input  logic             fs_Borr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
  logic [WIDTH-1:0]   diff_res_q, diff_res_d;
  logic               borr_res_q, borr_res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      brw_q      <= 1'b0;
      cnt_q      <= '0;
      diff_sr_q  <= '0;
      diff_res_q <= '0;
      borr_res_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      brw_q      <= brw_d;
      cnt_q      <= cnt_d;
      diff_sr_q  <= diff_sr_d;
      diff_res_q <= diff_res_d;
      borr_res_q <= borr_res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    brw_d      = brw_q;
    cnt_d      = cnt_q;
    diff_sr_d  = diff_sr_q;
    diff_res_d = diff_res_q;
    borr_res_d = borr_res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d     = A;
          opb_d     = B;
          brw_d     = Bin;
          cnt_d     = '0;
          diff_sr_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Cell outputs are combinational from fs_*, so they are consumed on the same edge.
        diff_sr_d = {fs_Diff, diff_sr_q[WIDTH-1:1]};
        brw_d     = fs_Borr;
        opa_d     = opa_q >> 1;
        opb_d     = opb_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_res_d = {fs_Diff, diff_sr_q[WIDTH-1:1]};
          borr_res_d = fs_Borr;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fs_A   = (state_q == SHIFT) & opa_q[0];
  assign fs_B   = (state_q == SHIFT) & opb_q[0];
  assign fs_Bin = (state_q == SHIFT) & brw_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign Diff   = diff_res_q;
  assign Borr   = borr_res_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and exhaustive checks of serial_subtractor_ctrl with a behavioural
// full subtractor cell closing the loop on fs_*.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       fs_a8, fs_b8, fs_bin8, fs_diff8, fs_borr8;
  logic       busy8, done8, borr8;
  logic [7:0] diff8;

  logic       start3, bin3;
  logic [2:0] a3, b3;
  logic       fs_a3, fs_b3, fs_bin3, fs_diff3, fs_borr3;
  logic       busy3, done3, borr3;
  logic [2:0] diff3;

  int n_checks;
  int n_errs;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .fs_A(fs_a8), .fs_B(fs_b8), .fs_Bin(fs_bin8), .fs_Diff(fs_diff8), .fs_Borr(fs_borr8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borr(borr8)
  );

  serial_subtractor_ctrl #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A(a3), .B(b3), .Bin(bin3),
    .fs_A(fs_a3), .fs_B(fs_b3), .fs_Bin(fs_bin3), .fs_Diff(fs_diff3), .fs_Borr(fs_borr3),
    .busy(busy3), .done(done3), .Diff(diff3), .Borr(borr3)
  );

  // Full subtractor cell models
  assign fs_diff8 = fs_a8 ^ fs_b8 ^ fs_bin8;
  assign fs_borr8 = (~fs_a8 & fs_b8) | (~(fs_a8 ^ fs_b8) & fs_bin8);
  assign fs_diff3 = fs_a3 ^ fs_b3 ^ fs_bin3;
  assign fs_borr3 = (~fs_a3 & fs_b3) | (~(fs_a3 ^ fs_b3) & fs_bin3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 run, checking the busy window, fs_A/fs_B bit order and the result.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] exp_diff, input logic exp_borr,
                      output logic [7:0] bin_seq);
    logic [7:0] a_seq, b_seq;
    int busy_cnt;
    a_seq = '0; b_seq = '0; bin_seq = '0; busy_cnt = 0;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bin;
    for (int k = 0; k < 8; k++) begin
      if (busy8 === 1'b1 && done8 === 1'b0) busy_cnt++;
      a_seq[k] = fs_a8; b_seq[k] = fs_b8; bin_seq[k] = fs_bin8;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 8);
    check("fs_A_seq", a_seq, a);
    check("fs_B_seq", b_seq, b);
    check("done_pulse", {busy8, done8}, 2'b01);
    check("fs_Bin_done", fs_bin8, 1'b0);
    check("diff", diff8, exp_diff);
    check("borr", borr8, exp_borr);
    @(negedge clk);
    check("done_low", done8, 1'b0);
    check("diff_held", {borr8, diff8}, {exp_borr, exp_diff});
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic bin);
    logic [3:0] ref_v;
    int n_done;
    logic [2:0] got_diff;
    logic got_borr;
    ref_v = {1'b0, a} - {1'b0, b} - {3'b000, bin};
    n_done = 0; got_diff = '0; got_borr = 1'b0;
    a3 = a; b3 = b; bin3 = bin; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done3 === 1'b1) begin
        n_done++;
        got_diff = diff3;
        got_borr = borr3;
      end
      @(negedge clk);
    end
    check("w3_done_once", n_done, 1);
    check("w3_diff", got_diff, ref_v[2:0]);
    check("w3_borr", got_borr, ref_v[3]);
  endtask

  initial begin
    logic [7:0] seq;
    int k1, k2;
    bit seen;
    n_checks = 0; n_errs = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    #3;
    check("rst_busy_done", {busy8, done8}, 2'b00);
    check("rst_result", {borr8, diff8}, 9'h000);
    check("rst_fs", {fs_a8, fs_b8, fs_bin8}, 3'b000);
    check("rst_w3", {busy3, done3, borr3, diff3}, 6'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, seq);
    check("bin_seq_5a_3c", seq, 8'b0111_1000);
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, seq);
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, seq);
    run8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, seq);
    check("bin_seq_80_7f", seq, 8'hFF);
    run8(8'hC8, 8'h32, 1'b1, 8'h95, 1'b0, seq);

    // start held high with new operands mid-run: ignored, back-to-back period WIDTH+2
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h11;
    k1 = 1; seen = 0;
    while (!seen && k1 < 30) begin
      if (done8 === 1'b1) seen = 1;
      else begin @(negedge clk); k1++; end
    end
    check("hold_first_lat", k1, 9);
    check("hold_first_res", {borr8, diff8}, 9'h1DE);
    @(negedge clk);
    k2 = 1; seen = 0;
    while (!seen && k2 < 30) begin
      if (done8 === 1'b1) seen = 1;
      else begin @(negedge clk); k2++; end
    end
    start8 = 1'b0;
    check("hold_period", k2, 10);
    check("hold_second_res", {borr8, diff8}, 9'h099);
    @(negedge clk);
    @(negedge clk);
    check("hold_no_third", busy8, 1'b0);

    // reset asserted while cnt==4
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("pre_rst_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {busy8, done8}, 2'b00);
    check("mid_rst_result", {borr8, diff8}, 9'h000);
    check("mid_rst_fs", {fs_a8, fs_b8, fs_bin8}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1;
      @(negedge clk);
    end
    check("post_rst_quiet", seen, 1'b0);
    run8(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, seq);

    // WIDTH=3 exhaustive
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      run3(v[6:4], v[3:1], v[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
